// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: opcode
// constants, the controller state set, and the datapath mux encodings
// that the controller drives and the datapath decodes.
package riscv_ctrl_pkg;

    // RV32I major opcodes (instruction bits [6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // pc_src: next-PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;  // PC + 4 from the ALU
    localparam logic [1:0] PC_SRC_TARGET = 2'b01;  // old_pc + imm adder
    localparam logic [1:0] PC_SRC_JALR   = 2'b10;  // ALU result, bit 0 cleared

    // alu_src_a: ALU operand A select
    localparam logic ALU_A_RS1 = 1'b0;
    localparam logic ALU_A_PC  = 1'b1;

    // alu_src_b: ALU operand B select
    localparam logic [1:0] ALU_B_RS2  = 2'b00;
    localparam logic [1:0] ALU_B_IMM  = 2'b01;
    localparam logic [1:0] ALU_B_FOUR = 2'b10;

    // alu_op: ALU operation class handed to the ALU decoder
    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

    // wb_sel: register-file write-back source select
    localparam logic [1:0] WB_ALU_OUT = 2'b00;
    localparam logic [1:0] WB_MDR     = 2'b01;
    localparam logic [1:0] WB_PC4     = 2'b10;
    localparam logic [1:0] WB_IMM     = 2'b11;

    // Controller states
    typedef enum logic [3:0] {
        S_START    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_EXEC_I   = 4'd8,
        S_AUIPC    = 4'd9,
        S_ALU_WB   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JAL      = 4'd12,
        S_JALR     = 4'd13,
        S_LUI      = 4'd14
    } state_t;

    // Full per-state control word; every field defaults to 0
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       illegal;
        logic       instr_done;
    } ctrl_word_t;

    // True for a store; used to split the shared address-calculation state
    function automatic logic is_store(input logic [6:0] op);
        return (op == OP_STORE);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_opclass.sv
// Combinational opcode classifier: maps the IR opcode to the state that
// follows DECODE, flags unknown opcodes, and picks the memory direction
// after the shared address-calculation state.
module ctrl_opclass
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output state_t     decode_next,
    output logic       decode_illegal,
    output state_t     mem_next
);

    // Opcode to post-DECODE state; unknown opcodes retire as a NOP
    always_comb begin
        decode_next    = S_FETCH;
        decode_illegal = 1'b0;
        case (opcode)
            OP_LOAD,
            OP_STORE:  decode_next = S_MEM_ADDR;
            OP_RTYPE:  decode_next = S_EXEC_R;
            OP_ITYPE:  decode_next = S_EXEC_I;
            OP_AUIPC:  decode_next = S_AUIPC;
            OP_BRANCH: decode_next = S_BRANCH;
            OP_JAL:    decode_next = S_JAL;
            OP_JALR:   decode_next = S_JALR;
            OP_LUI:    decode_next = S_LUI;
            default: begin
                decode_next    = S_FETCH;
                decode_illegal = 1'b1;
            end
        endcase
    end

    // Only loads and stores reach MEM_ADDR, so anything but a store reads
    always_comb begin
        mem_next = is_store(opcode) ? S_MEM_WR : S_MEM_RD;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM for the RV32I core. Holds the state
// register and decodes a control word per state for the shared ALU,
// unified memory port and register file. Memory states wait on mem_ready.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       illegal,
    output logic       instr_done
);

    state_t     state_reg;
    state_t     state_next;
    state_t     decode_next;
    state_t     mem_next;
    logic       decode_illegal;
    ctrl_word_t cw;

    ctrl_opclass u_opclass (
        .opcode         (opcode),
        .decode_next    (decode_next),
        .decode_illegal (decode_illegal),
        .mem_next       (mem_next)
    );

    // State register; reset forces START immediately so a pending
    // mem_req/mem_we drops without waiting for a clock edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_START;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state selection; memory states hold until mem_ready
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_START:    state_next = S_FETCH;
            S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   state_next = decode_next;
            S_MEM_ADDR: state_next = mem_next;
            S_MEM_RD:   state_next = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   state_next = S_FETCH;
            S_MEM_WR:   state_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC_R,
            S_EXEC_I,
            S_AUIPC:    state_next = S_ALU_WB;
            S_ALU_WB,
            S_BRANCH,
            S_JAL,
            S_JALR,
            S_LUI:      state_next = S_FETCH;
            default:    state_next = S_START;
        endcase
    end

    // Per-state control word; fields not set in a state stay 0
    always_comb begin
        cw = '0;
        case (state_reg)
            S_FETCH: begin
                // PC+4 is computed while the instruction is read; IR and PC
                // are only loaded on the cycle the memory answers
                cw.mem_req   = 1'b1;
                cw.i_or_d    = 1'b0;
                cw.alu_src_a = ALU_A_PC;
                cw.alu_src_b = ALU_B_FOUR;
                cw.alu_op    = ALU_OP_ADD;
                cw.pc_src    = PC_SRC_ALU;
                cw.ir_write  = mem_ready;
                cw.pc_write  = mem_ready;
            end
            S_DECODE: begin
                cw.illegal    = decode_illegal;
                cw.instr_done = decode_illegal;
            end
            S_MEM_ADDR: begin
                cw.alu_src_a = ALU_A_RS1;
                cw.alu_src_b = ALU_B_IMM;
                cw.alu_op    = ALU_OP_ADD;
            end
            S_MEM_RD: begin
                cw.mem_req = 1'b1;
                cw.i_or_d  = 1'b1;
            end
            S_MEM_WB: begin
                cw.reg_write  = 1'b1;
                cw.wb_sel     = WB_MDR;
                cw.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                // The store retires on the edge that accepts it
                cw.mem_req    = 1'b1;
                cw.mem_we     = 1'b1;
                cw.i_or_d     = 1'b1;
                cw.instr_done = mem_ready;
            end
            S_EXEC_R: begin
                cw.alu_src_a = ALU_A_RS1;
                cw.alu_src_b = ALU_B_RS2;
                cw.alu_op    = ALU_OP_RTYPE;
            end
            S_EXEC_I: begin
                cw.alu_src_a = ALU_A_RS1;
                cw.alu_src_b = ALU_B_IMM;
                cw.alu_op    = ALU_OP_ITYPE;
            end
            S_AUIPC: begin
                cw.alu_src_a = ALU_A_PC;
                cw.alu_src_b = ALU_B_IMM;
                cw.alu_op    = ALU_OP_ADD;
            end
            S_ALU_WB: begin
                cw.reg_write  = 1'b1;
                cw.wb_sel     = WB_ALU_OUT;
                cw.instr_done = 1'b1;
            end
            S_BRANCH: begin
                cw.alu_src_a     = ALU_A_RS1;
                cw.alu_src_b     = ALU_B_RS2;
                cw.alu_op        = ALU_OP_BRANCH;
                cw.pc_write_cond = 1'b1;
                cw.pc_src        = PC_SRC_TARGET;
                cw.instr_done    = 1'b1;
            end
            S_JAL: begin
                cw.pc_write   = 1'b1;
                cw.pc_src     = PC_SRC_TARGET;
                cw.reg_write  = 1'b1;
                cw.wb_sel     = WB_PC4;
                cw.instr_done = 1'b1;
            end
            S_JALR: begin
                cw.alu_src_a  = ALU_A_RS1;
                cw.alu_src_b  = ALU_B_IMM;
                cw.alu_op     = ALU_OP_ADD;
                cw.pc_write   = 1'b1;
                cw.pc_src     = PC_SRC_JALR;
                cw.reg_write  = 1'b1;
                cw.wb_sel     = WB_PC4;
                cw.instr_done = 1'b1;
            end
            S_LUI: begin
                cw.reg_write  = 1'b1;
                cw.wb_sel     = WB_IMM;
                cw.instr_done = 1'b1;
            end
            default: begin
                cw = '0;
            end
        endcase
    end

    assign mem_req       = cw.mem_req;
    assign mem_we        = cw.mem_we;
    assign i_or_d        = cw.i_or_d;
    assign ir_write      = cw.ir_write;
    assign pc_write      = cw.pc_write;
    assign pc_write_cond = cw.pc_write_cond;
    assign pc_src        = cw.pc_src;
    assign alu_src_a     = cw.alu_src_a;
    assign alu_src_b     = cw.alu_src_b;
    assign alu_op        = cw.alu_op;
    assign reg_write     = cw.reg_write;
    assign wb_sel        = cw.wb_sel;
    assign illegal       = cw.illegal;
    assign instr_done    = cw.instr_done;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl. A per-instruction model expands each
// instruction (opcode plus fetch/memory wait counts) into the list of
// cycles it must take and the control outputs required in each; one
// process replays that list, driving mem_ready and checking every cycle.
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_src, alu_src_b, alu_op, wb_sel;
    logic       alu_src_a, reg_write, illegal, instr_done;

    multicycle_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .i_or_d        (i_or_d),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .wb_sel        (wb_sel),
        .illegal       (illegal),
        .instr_done    (instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       illegal;
        logic       instr_done;
    } outs_t;

    typedef struct {
        outs_t o;
        logic  rdy;    // mem_ready value to drive this cycle
        logic  care;   // 0: mem_ready is irrelevant, drive a random bit
        string tag;
    } cyc_t;

    cyc_t q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   done_seen = 0;
    int   done_exp  = 0;

    // ---------------- model ----------------
    function automatic void push(input string tag, input outs_t o,
                                 input logic rdy, input logic care);
        cyc_t c;
        c.o = o; c.rdy = rdy; c.care = care; c.tag = tag;
        q.push_back(c);
    endfunction

    // Expand one instruction into its expected cycle list
    function automatic void build(input logic [6:0] op, input int fw, input int mw);
        outs_t o;
        q.delete();
        // instruction fetch: request from PC while PC+4 is formed
        for (int i = 0; i < fw; i++) begin
            o = '0; o.mem_req = 1; o.alu_src_a = 1; o.alu_src_b = 2'b10;
            push("fetch_wait", o, 1'b0, 1'b1);
        end
        o = '0; o.mem_req = 1; o.alu_src_a = 1; o.alu_src_b = 2'b10;
        o.ir_write = 1; o.pc_write = 1;
        push("fetch", o, 1'b1, 1'b1);
        // decode
        o = '0;
        case (op)
            7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0010111,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111: begin
                push("decode", o, 1'b0, 1'b0);
            end
            default: begin
                o.illegal = 1; o.instr_done = 1;
                push("decode_illegal", o, 1'b0, 1'b0);
                return;
            end
        endcase
        case (op)
            7'b0000011: begin   // load: address, read with waits, write back
                o = '0; o.alu_src_b = 2'b01; push("mem_addr", o, 1'b0, 1'b0);
                for (int i = 0; i < mw; i++) begin
                    o = '0; o.mem_req = 1; o.i_or_d = 1; push("mem_rd_wait", o, 1'b0, 1'b1);
                end
                o = '0; o.mem_req = 1; o.i_or_d = 1; push("mem_rd", o, 1'b1, 1'b1);
                o = '0; o.reg_write = 1; o.wb_sel = 2'b01; o.instr_done = 1;
                push("mem_wb", o, 1'b0, 1'b0);
            end
            7'b0100011: begin   // store: address, write with waits, retire on accept
                o = '0; o.alu_src_b = 2'b01; push("mem_addr", o, 1'b0, 1'b0);
                for (int i = 0; i < mw; i++) begin
                    o = '0; o.mem_req = 1; o.mem_we = 1; o.i_or_d = 1;
                    push("mem_wr_wait", o, 1'b0, 1'b1);
                end
                o = '0; o.mem_req = 1; o.mem_we = 1; o.i_or_d = 1; o.instr_done = 1;
                push("mem_wr", o, 1'b1, 1'b1);
            end
            7'b0110011, 7'b0010011, 7'b0010111: begin
                o = '0;
                if (op == 7'b0110011) begin o.alu_op = 2'b10; end
                else if (op == 7'b0010011) begin o.alu_src_b = 2'b01; o.alu_op = 2'b11; end
                else begin o.alu_src_a = 1; o.alu_src_b = 2'b01; end
                push("execute", o, 1'b0, 1'b0);
                o = '0; o.reg_write = 1; o.instr_done = 1;
                push("alu_wb", o, 1'b0, 1'b0);
            end
            7'b1100011: begin
                o = '0; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_src = 2'b01;
                o.instr_done = 1; push("branch", o, 1'b0, 1'b0);
            end
            7'b1101111: begin
                o = '0; o.pc_write = 1; o.pc_src = 2'b01; o.reg_write = 1;
                o.wb_sel = 2'b10; o.instr_done = 1; push("jal", o, 1'b0, 1'b0);
            end
            7'b1100111: begin
                o = '0; o.alu_src_b = 2'b01; o.pc_write = 1; o.pc_src = 2'b10;
                o.reg_write = 1; o.wb_sel = 2'b10; o.instr_done = 1;
                push("jalr", o, 1'b0, 1'b0);
            end
            default: begin  // lui
                o = '0; o.reg_write = 1; o.wb_sel = 2'b11; o.instr_done = 1;
                push("lui", o, 1'b0, 1'b0);
            end
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic compare(input outs_t exp, input string tag);
        outs_t act;
        act = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, illegal, instr_done};
        checks++;
        if (act.instr_done === 1'b1) done_seen++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: got %b required %b", tag, $time, act, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", tag, got, want);
        end
    endtask

    // Replay the current cycle list; limit < 0 plays it to the end
    task automatic play(input string name, input logic [6:0] op, input int limit);
        int n;
        n = 0;
        foreach (q[i]) begin
            if (limit >= 0 && n >= limit) break;
            @(posedge clk);
            #1;
            if (n == 0) opcode = op;
            mem_ready = q[i].care ? q[i].rdy : 1'($urandom_range(0, 1));
            #3;
            compare(q[i].o, {name, ".", q[i].tag});
            n++;
        end
        if (limit < 0) done_exp++;
        $display("instr %-8s op=%b cycles=%0d", name, op, n);
    endtask

    task automatic run(input string name, input logic [6:0] op, input int fw, input int mw);
        build(op, fw, mw);
        play(name, op, -1);
    endtask

    // Watchdog: the sequence is fixed-length, this only guards a hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        opcode    = 7'b0;
        mem_ready = 1'b0;

        // Pin the model's latencies against hand-derived cycle counts
        build(7'b0000011, 0, 0); check_int("lat_load",   q.size(), 5);
        build(7'b0100011, 0, 0); check_int("lat_store",  q.size(), 4);
        build(7'b0110011, 0, 0); check_int("lat_rtype",  q.size(), 4);
        build(7'b0010011, 0, 0); check_int("lat_itype",  q.size(), 4);
        build(7'b0010111, 0, 0); check_int("lat_auipc",  q.size(), 4);
        build(7'b1100011, 0, 0); check_int("lat_branch", q.size(), 3);
        build(7'b1101111, 0, 0); check_int("lat_jal",    q.size(), 3);
        build(7'b1100111, 0, 0); check_int("lat_jalr",   q.size(), 3);
        build(7'b0110111, 0, 0); check_int("lat_lui",    q.size(), 3);
        build(7'b0000000, 0, 0); check_int("lat_illegal", q.size(), 2);
        build(7'b0000011, 2, 3); check_int("lat_load_waits", q.size(), 10);

        // Outputs idle while reset is held
        repeat (2) @(posedge clk);
        #4 compare('0, "reset_held");
        mem_ready = 1'b1;
        #1 compare('0, "reset_held_ready");

        // Release; one START cycle with all outputs 0
        @(posedge clk);
        #1 reset = 1'b0;
        #3 compare('0, "start");

        run("rtype",   7'b0110011, 0, 0);
        run("load",    7'b0000011, 2, 3);
        run("store",   7'b0100011, 0, 0);
        run("branch",  7'b1100011, 0, 0);
        run("jalr",    7'b1100111, 0, 0);
        run("jal",     7'b1101111, 0, 0);
        run("lui",     7'b0110111, 0, 0);
        run("auipc",   7'b0010111, 0, 0);
        run("itype",   7'b0010011, 1, 0);
        run("ill_00",  7'b0000000, 0, 0);
        run("ill_7f",  7'b1111111, 1, 0);
        run("store_w", 7'b0100011, 1, 2);
        run("load",    7'b0000011, 0, 0);

        // Reset during a stalled store: request and write drop at once
        build(7'b0100011, 0, 3);
        play("store_rst", 7'b0100011, 4);
        mem_ready = 1'b1;
        #1 reset = 1'b1;
        #1 compare('0, "reset_mid_wr");
        @(posedge clk);
        #4 compare('0, "reset_mid_wr_held");
        @(posedge clk);
        #1 reset = 1'b0;
        mem_ready = 1'b0;
        #3 compare('0, "start_after_rst");
        run("rtype",   7'b0110011, 0, 1);

        // One instr_done per completed instruction, none for the aborted store
        check_int("instr_done_count", done_seen, done_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
